// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction loader.
// The checksum state exists only when LOADER_CHECKSUM_EN is defined.
package instr_loader_pkg;

  localparam int unsigned WORD_W            = 32;
  localparam int unsigned BYTE_W            = 8;
  localparam int unsigned BYTES_PER_WORD    = WORD_W / BYTE_W;
  localparam int unsigned BCNT_W            = $clog2(BYTES_PER_WORD);
  localparam int unsigned CNT_W             = BYTE_W;
  localparam int unsigned DEFAULT_MEM_DEPTH = 11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
`ifdef LOADER_CHECKSUM_EN
    S_CSUM  = 3'd4,
`endif
    S_FIN   = 3'd5
  } state_t;

  // States in which the loader takes a stream byte.
  function automatic logic ready_state(input state_t s);
    logic r;
    r = (s == S_LEN) || (s == S_DATA);
`ifdef LOADER_CHECKSUM_EN
    r = r || (s == S_CSUM);
`endif
    return r;
  endfunction

endpackage

// File: rtl/instr_byte_packer.sv
// Collects four stream bytes, MSB first, into one instruction word.
// word_valid_c flags the cycle the fourth byte arrives; word_c is the word it completes.
module instr_byte_packer
  import instr_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              byte_en,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word_c,
  output logic              word_valid_c
);

  logic [BCNT_W-1:0] cnt_q, cnt_next;
  logic [WORD_W-1:0] sr_q, sr_next;

  always_comb begin
    cnt_next     = cnt_q;
    sr_next      = sr_q;
    word_c       = {sr_q[WORD_W-BYTE_W-1:0], byte_in};
    word_valid_c = byte_en && (cnt_q == BCNT_W'(BYTES_PER_WORD - 1));
    if (clr) begin
      cnt_next = '0;
      sr_next  = '0;
    end else if (byte_en) begin
      cnt_next = cnt_q + BCNT_W'(1);
      sr_next  = word_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      sr_q  <= '0;
    end else begin
      cnt_q <= cnt_next;
      sr_q  <= sr_next;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Loads a length-prefixed byte stream into instruction memory, one word per write.
// Define LOADER_CHECKSUM_EN to require a trailing modulo-256 checksum byte.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = DEFAULT_MEM_DEPTH,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [31:0] DEPTH_LIM = 32'(MEM_DEPTH);

  state_t            state_q, state_next;
  logic [CNT_W-1:0]  len_q, len_next;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_next;
  logic [CNT_W:0]    word_cnt_inc_c;
  logic              err_next;
  logic              in_ready_next, mem_we_next, busy_next, done_next;
  logic [ADDR_W-1:0] mem_addr_next;
  logic [WORD_W-1:0] mem_wdata_next;
  logic              xfer_c, pack_clr_c, pack_en_c;
  logic [WORD_W-1:0] word_c;
  logic              word_valid_c;
`ifdef LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] csum_q, csum_next;
`endif

  assign xfer_c         = in_valid && in_ready;
  assign pack_en_c      = xfer_c && (state_q == S_DATA);
  assign word_cnt_inc_c = {1'b0, word_cnt_q} + (CNT_W + 1)'(1);

  instr_byte_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .clr          (pack_clr_c),
    .byte_en      (pack_en_c),
    .byte_in      (in_data),
    .word_c       (word_c),
    .word_valid_c (word_valid_c)
  );

  // Next-state and registered-output decode.
  always_comb begin
    state_next     = state_q;
    len_next       = len_q;
    word_cnt_next  = word_cnt_q;
    err_next       = err;
    mem_addr_next  = mem_addr;
    mem_wdata_next = mem_wdata;
    pack_clr_c     = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    csum_next      = csum_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_next   = 1'b0;
          state_next = S_LEN;
        end
      end
      S_LEN: begin
        if (xfer_c) begin
          if ((in_data == '0) || (32'(in_data) > DEPTH_LIM)) begin
            err_next   = 1'b1;
            state_next = S_FIN;
          end else begin
            len_next      = in_data;
            word_cnt_next = '0;
            pack_clr_c    = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            csum_next     = '0;
`endif
            state_next    = S_DATA;
          end
        end
      end
      S_DATA: begin
`ifdef LOADER_CHECKSUM_EN
        if (xfer_c) csum_next = csum_q + in_data;
`endif
        if (word_valid_c) begin
          mem_addr_next  = ADDR_W'(word_cnt_q);
          mem_wdata_next = word_c;
          state_next     = S_WRITE;
        end
      end
      S_WRITE: begin
        word_cnt_next = word_cnt_inc_c[CNT_W-1:0];
        if (word_cnt_inc_c < {1'b0, len_q}) begin
          state_next = S_DATA;
        end else begin
`ifdef LOADER_CHECKSUM_EN
          state_next = S_CSUM;
`else
          state_next = S_FIN;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (xfer_c) begin
          if (in_data != csum_q) err_next = 1'b1;
          state_next = S_FIN;
        end
      end
`endif
      S_FIN: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Outputs are registered as a decode of the state being entered.
    in_ready_next = ready_state(state_next);
    busy_next     = (state_next != S_IDLE);
    done_next     = (state_next == S_FIN);
    mem_we_next   = (state_next == S_WRITE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      word_cnt_q <= '0;
      in_ready   <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_next;
      len_q      <= len_next;
      word_cnt_q <= word_cnt_next;
      in_ready   <= in_ready_next;
      mem_we     <= mem_we_next;
      mem_addr   <= mem_addr_next;
      mem_wdata  <= mem_wdata_next;
      busy       <= busy_next;
      done       <= done_next;
      err        <= err_next;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= csum_next;
`endif
    end
  end

endmodule
